// File: rtl/inst_fetch_if.sv
// Instruction memory read bus: registered request/address out, variable-latency ack/data back.
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: turns pc into a memory read, holds the fetched word with its address tag,
// stalls until the tag matches pc, and flags misaligned pc / bus timeout as a sticky fault.
module inst_fetch #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_WORD = '0
) (
  input  logic               clk_cpu,
  input  logic               reset,
  input  logic [31:0]        pc,
  inst_fetch_if.master       mem,
  output logic [31:0]        inst,
  output logic               inst_valid,
  output logic               fetch_stall,
  output logic               fetch_fault
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state, state_nxt;
  logic [31:0] tag;
  logic        tag_v;
  logic        fault;
  logic [7:0]  tmo_cnt;

  logic hit, misal, blocked, timeout;

  assign hit     = tag_v && (tag == pc);
  assign misal   = (pc[1:0] != 2'b00);
  // a faulted address is not retried until pc moves off it
  assign blocked = fault && (tag == pc);
  assign timeout = (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!hit && !misal && !blocked) state_nxt = REQ;
      REQ:  if (mem.mem_ack || timeout)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inst_valid  = hit;
    fetch_fault = fault;
    fetch_stall = !hit && !fault;
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      inst         <= NOP_WORD;
      tag          <= '0;
      tag_v        <= 1'b0;
      fault        <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (!hit) begin
          if (misal) begin
            fault <= 1'b1;
            inst  <= NOP_WORD;
            tag   <= pc;
            tag_v <= 1'b0;
          end else if (!blocked) begin
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= pc;
            tmo_cnt      <= '0;
            fault        <= 1'b0;
          end
        end
        REQ: begin
          // ack has priority over a timeout landing on the same edge
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            inst        <= mem.mem_rdata;
            tag         <= mem.mem_addr;
            tag_v       <= 1'b1;
            fault       <= 1'b0;
          end else if (timeout) begin
            mem.mem_req <= 1'b0;
            fault       <= 1'b1;
            inst        <= NOP_WORD;
            tag         <= mem.mem_addr;
            tag_v       <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
